// File: rtl/instrq_pkg.sv
// Shared definitions for the instruction-queue side-data FIFO.
`ifndef instrQExtra_width
`define instrQExtra_width 8
`endif

package instrq_pkg;

  // Default bits per side-data entry, tied to the backend-wide macro.
  localparam int unsigned IqsDataWidth = `instrQExtra_width;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned iqs_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) begin
      r++;
    end
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int unsigned iqs_idx_width(input int unsigned n);
    int unsigned w;
    w = iqs_clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // Occupancy at which the front end must stop: one more full write must still fit.
  function automatic int iqs_stall_threshold(input int depth, input int wr_ports, input int slack);
    return depth - wr_ports + 1 - slack;
  endfunction

endpackage

// File: rtl/iqs_thread_ctrl.sv
// Per-thread ring bookkeeping: pointers, occupancy, clamped dequeue, stall and flush.
module iqs_thread_ctrl
  import instrq_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned WR_PORTS     = 4,
  parameter int unsigned FSTALL_SLACK = 0,
  localparam int unsigned CW          = iqs_clog2(DEPTH + 1),
  localparam int unsigned PW          = iqs_clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [CW-1:0] wr_num_i,
  input  logic          rd_en_i,
  input  logic [CW-1:0] rd_req_i,
  input  logic          flush_i,
  output logic [CW-1:0] cnt_o,
  output logic [CW-1:0] cnt_next_o,
  output logic [PW-1:0] wr_ptr_o,
  output logic [PW-1:0] rd_ptr_next_o,
  output logic          underflow_o,
  output logic          do_fstall_o
);

  localparam int StallThresh = iqs_stall_threshold(DEPTH, WR_PORTS, FSTALL_SLACK);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] eff;
  logic [CW-1:0] wr_num;

  // Next-state: dequeue is clamped to what is held; flush wins over everything.
  always_comb begin
    eff         = '0;
    underflow_o = 1'b0;
    if (rd_en_i) begin
      eff         = (rd_req_i > cnt_q) ? cnt_q : rd_req_i;
      underflow_o = rd_req_i > cnt_q;
    end
    wr_num   = wr_en_i ? wr_num_i : '0;
    cnt_d    = cnt_q + wr_num - eff;
    wr_ptr_d = wr_ptr_q + wr_num[PW-1:0];
    rd_ptr_d = rd_ptr_q + eff[PW-1:0];
    if (flush_i) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Overflow is only reachable if the front end ignores do_fstall_o.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_en_i && !flush_i) begin
      assert (32'(cnt_q) + 32'(wr_num_i) <= DEPTH);
    end
  end

  // Stall is derived from the registered count only, so it is glitch-free to the front end.
  always_comb begin
    do_fstall_o   = int'(cnt_q) >= StallThresh;
    cnt_o         = cnt_q;
    cnt_next_o    = cnt_d;
    wr_ptr_o      = wr_ptr_q;
    rd_ptr_next_o = rd_ptr_d;
  end

endmodule

// File: rtl/instrq_side_fifo.sv
// Per-thread side-data queue beside the main instruction queue: packed multi-lane
// enqueue, RD_PORTS-wide peek window, per-thread stall, flush and sticky error flags.
module instrq_side_fifo
  import instrq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = IqsDataWidth,
  parameter int unsigned THREADS      = 2,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned WR_PORTS     = 4,
  parameter int unsigned RD_PORTS     = 2,
  parameter int unsigned FSTALL_SLACK = 0
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      except,
  input  logic [iqs_idx_width(THREADS)-1:0]         except_thread,
  input  logic                                      fStall,
  output logic [THREADS-1:0]                        doFStall,
  input  logic                                      stall,
  input  logic [iqs_idx_width(THREADS)-1:0]         read_thread,
  input  logic [iqs_clog2(RD_PORTS+1)-1:0]          read_cnt,
  output logic [RD_PORTS*DATA_WIDTH-1:0]            read_data,
  output logic [RD_PORTS-1:0]                       read_vld,
  input  logic                                      write_wen,
  input  logic [iqs_idx_width(THREADS)-1:0]         write_thread,
  input  logic [iqs_idx_width(WR_PORTS)-1:0]        write_first,
  input  logic [iqs_clog2(WR_PORTS+1)-1:0]          write_cnt,
  input  logic [WR_PORTS*DATA_WIDTH-1:0]            write_data,
  output logic [THREADS*iqs_clog2(DEPTH+1)-1:0]     occupancy,
  output logic                                      err_underflow,
  output logic                                      err_lanes
);

  localparam int unsigned TW = iqs_idx_width(THREADS);
  localparam int unsigned CW = iqs_clog2(DEPTH + 1);
  localparam int unsigned PW = iqs_clog2(DEPTH);
  localparam int unsigned AW = TW + PW;

  logic                wacc;
  logic                lane_ovf;
  logic [CW-1:0]       wr_num;
  logic [CW-1:0]       cnt      [THREADS];
  logic [CW-1:0]       cnt_next [THREADS];
  logic [PW-1:0]       wr_ptr   [THREADS];
  logic [PW-1:0]       rd_ptr_next [THREADS];
  logic [THREADS-1:0]  underflow;

  logic [DATA_WIDTH-1:0]         mem_q [2**AW];
  logic [RD_PORTS-1:0][AW-1:0]   raddr_q;
  logic [RD_PORTS-1:0]           rvld_q;
  logic                          err_underflow_q;
  logic                          err_lanes_q;

  // Write acceptance and the number of lanes actually taken; lanes past the top are dropped.
  always_comb begin
    wacc     = write_wen & ~fStall & ~doFStall[write_thread] & (write_cnt != '0);
    lane_ovf = (32'(write_first) + 32'(write_cnt)) > WR_PORTS;
    wr_num   = CW'(write_cnt);
    if (lane_ovf) begin
      wr_num = (32'(write_first) < WR_PORTS) ? CW'(WR_PORTS - 32'(write_first)) : '0;
    end
  end

  for (genvar t = 0; t < THREADS; t++) begin : g_thread
    iqs_thread_ctrl #(
      .DEPTH        (DEPTH),
      .WR_PORTS     (WR_PORTS),
      .FSTALL_SLACK (FSTALL_SLACK)
    ) u_ctrl (
      .clk_i         (clk),
      .rst_i         (rst),
      .wr_en_i       (wacc && (write_thread == TW'(t))),
      .wr_num_i      (wr_num),
      .rd_en_i       (~stall && (read_thread == TW'(t))),
      .rd_req_i      (CW'(read_cnt)),
      .flush_i       (except && (except_thread == TW'(t))),
      .cnt_o         (cnt[t]),
      .cnt_next_o    (cnt_next[t]),
      .wr_ptr_o      (wr_ptr[t]),
      .rd_ptr_next_o (rd_ptr_next[t]),
      .underflow_o   (underflow[t]),
      .do_fstall_o   (doFStall[t])
    );
    assign occupancy[t*CW +: CW] = cnt[t];
  end

  // Multi-lane RAM write; storage is not reset.
  always_ff @(posedge clk) begin
    if (wacc) begin
      for (int unsigned k = 0; k < WR_PORTS; k++) begin
        if (k < 32'(wr_num)) begin
          mem_q[{write_thread, wr_ptr[write_thread] + PW'(k)}] <=
            write_data[(32'(write_first) + k) * DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Peek window tracks the post-update head of read_thread; frozen while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raddr_q <= '0;
      rvld_q  <= '0;
    end else if (!stall) begin
      for (int i = 0; i < RD_PORTS; i++) begin
        raddr_q[i] <= {read_thread, rd_ptr_next[read_thread] + PW'(i)};
        rvld_q[i]  <= !(except && (except_thread == read_thread)) &&
                      (cnt_next[read_thread] > CW'(i));
      end
    end
  end

  // Asynchronous read so a same-edge write is already visible in the window.
  always_comb begin
    read_data = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      read_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[raddr_q[i]];
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_underflow_q <= 1'b0;
      err_lanes_q     <= 1'b0;
    end else begin
      if (|underflow) err_underflow_q <= 1'b1;
      if (wacc && lane_ovf) err_lanes_q <= 1'b1;
    end
  end

  assign read_vld      = rvld_q;
  assign err_underflow = err_underflow_q;
  assign err_lanes     = err_lanes_q;

endmodule

// File: tb/tb_instrq_side_fifo.sv
// Self-checking bench for instrq_side_fifo: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_instrq_side_fifo;

  localparam int DW    = 8;
  localparam int TH    = 2;
  localparam int DEPTH = 16;
  localparam int WR    = 4;
  localparam int RD    = 2;
  localparam int SLACK = 0;
  localparam int CW    = 5;
  localparam int THR   = DEPTH - WR + 1 - SLACK;

  logic        clk = 1'b0;
  logic        rst;
  logic        except;
  logic [0:0]  except_thread;
  logic        fStall;
  logic [1:0]  doFStall;
  logic        stall;
  logic [0:0]  read_thread;
  logic [1:0]  read_cnt;
  logic [15:0] read_data;
  logic [1:0]  read_vld;
  logic        write_wen;
  logic [0:0]  write_thread;
  logic [1:0]  write_first;
  logic [2:0]  write_cnt;
  logic [31:0] write_data;
  logic [9:0]  occupancy;
  logic        err_underflow;
  logic        err_lanes;

  int checks = 0;
  int errors = 0;

  // Reference model: one FIFO queue per thread, plus the window snapshot and sticky flags.
  logic [7:0] mq [TH][$];
  int         win_thr;
  int         win_n;
  bit         m_err_u;
  bit         m_err_l;

  instrq_side_fifo #(
    .DATA_WIDTH   (DW),
    .THREADS      (TH),
    .DEPTH        (DEPTH),
    .WR_PORTS     (WR),
    .RD_PORTS     (RD),
    .FSTALL_SLACK (SLACK)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .except        (except),
    .except_thread (except_thread),
    .fStall        (fStall),
    .doFStall      (doFStall),
    .stall         (stall),
    .read_thread   (read_thread),
    .read_cnt      (read_cnt),
    .read_data     (read_data),
    .read_vld      (read_vld),
    .write_wen     (write_wen),
    .write_thread  (write_thread),
    .write_first   (write_first),
    .write_cnt     (write_cnt),
    .write_data    (write_data),
    .occupancy     (occupancy),
    .err_underflow (err_underflow),
    .err_lanes     (err_lanes)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1);
  end

  function automatic int occ(input int t);
    return int'(occupancy[t*CW +: CW]);
  endfunction

  function automatic logic [7:0] lane(input int i);
    return read_data[i*DW +: DW];
  endfunction

  function automatic logic [1:0] exp_vld();
    logic [1:0] v;
    v = '0;
    for (int i = 0; i < RD; i++) if (i < win_n) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [1:0] exp_fstall();
    logic [1:0] v;
    for (int t = 0; t < TH; t++) v[t] = (mq[t].size() >= THR);
    return v;
  endfunction

  task automatic idle();
    except = 0; except_thread = 0; fStall = 0; stall = 0;
    read_thread = 0; read_cnt = 0;
    write_wen = 0; write_thread = 0; write_first = 0; write_cnt = 0; write_data = '0;
  endtask

  task automatic model_reset();
    for (int t = 0; t < TH; t++) mq[t].delete();
    win_thr = 0; win_n = 0; m_err_u = 0; m_err_l = 0;
  endtask

  // One clock: apply the current inputs, advance the model, settle #1 past the edge.
  task automatic cycle();
    int  sz_w, sz_r, acc, eff;
    bit  wacc;
    sz_w = mq[write_thread].size();
    sz_r = mq[read_thread].size();
    wacc = write_wen && !fStall && (sz_w < THR) && (write_cnt != 0);
    acc  = 0;
    if (wacc) begin
      if (int'(write_first) + int'(write_cnt) > WR) begin
        acc = WR - int'(write_first);
        m_err_l = 1;
      end else begin
        acc = int'(write_cnt);
      end
    end
    eff = 0;
    if (!stall) begin
      eff = (int'(read_cnt) > sz_r) ? sz_r : int'(read_cnt);
      if (int'(read_cnt) > sz_r) m_err_u = 1;
    end
    @(posedge clk);
    for (int t = 0; t < TH; t++) begin
      if (except && t == int'(except_thread)) begin
        mq[t].delete();
      end else begin
        if (!stall && t == int'(read_thread)) repeat (eff) void'(mq[t].pop_front());
        if (wacc && t == int'(write_thread))
          for (int k = 0; k < acc; k++)
            mq[t].push_back(write_data[(int'(write_first) + k) * DW +: DW]);
      end
    end
    if (!stall) begin
      win_thr = int'(read_thread);
      win_n   = (mq[win_thr].size() < RD) ? mq[win_thr].size() : RD;
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (occ(0) != 0) begin errors++; $display("FAIL reset occ0: got %0d want 0", occ(0)); end
    checks++; if (occ(1) != 0) begin errors++; $display("FAIL reset occ1: got %0d want 0", occ(1)); end
    checks++; if (doFStall !== 2'b00) begin errors++; $display("FAIL reset doFStall: got %b want 00", doFStall); end
    checks++; if (read_vld !== 2'b00) begin errors++; $display("FAIL reset read_vld: got %b want 00", read_vld); end
    checks++; if ({err_underflow, err_lanes} !== 2'b00) begin
      errors++; $display("FAIL reset errs: got %b want 00", {err_underflow, err_lanes});
    end
    rst = 0;
  endtask

  task automatic test_write_first();
    idle();
    write_wen = 1; write_thread = 0; write_first = 1; write_cnt = 3;
    write_data = {8'hC3, 8'hB2, 8'hA1, 8'h5A};
    cycle();
    checks++; if (occ(0) != 3) begin errors++; $display("FAIL wfirst occ0: got %0d want 3", occ(0)); end
    checks++; if (read_vld !== 2'b11) begin errors++; $display("FAIL wfirst vld: got %b want 11", read_vld); end
    checks++; if (lane(0) !== 8'hA1) begin errors++; $display("FAIL wfirst lane0: got %h want a1", lane(0)); end
    checks++; if (lane(1) !== 8'hB2) begin errors++; $display("FAIL wfirst lane1: got %h want b2", lane(1)); end
  endtask

  task automatic test_fstall();
    idle();
    write_wen = 1; write_thread = 0; write_cnt = 4;
    write_data = $urandom; cycle();
    write_data = $urandom; cycle();
    write_cnt = 1; write_data = $urandom; cycle();
    checks++; if (occ(0) != 12) begin errors++; $display("FAIL fstall occ12: got %0d want 12", occ(0)); end
    checks++; if (doFStall !== 2'b00) begin errors++; $display("FAIL fstall at12: got %b want 00", doFStall); end
    write_data = $urandom; cycle();
    checks++; if (occ(0) != 13) begin errors++; $display("FAIL fstall occ13: got %0d want 13", occ(0)); end
    checks++; if (doFStall !== 2'b01) begin errors++; $display("FAIL fstall at13: got %b want 01", doFStall); end
    write_cnt = 4; write_data = $urandom; cycle();
    checks++; if (occ(0) != 13) begin errors++; $display("FAIL fstall blocked: got %0d want 13", occ(0)); end
  endtask

  task automatic test_underflow();
    idle();
    write_wen = 1; write_thread = 1; write_cnt = 1; write_data = 32'h0000_00D0;
    cycle();
    checks++; if (occ(1) != 1) begin errors++; $display("FAIL uflow occ1 pre: got %0d want 1", occ(1)); end
    idle(); read_thread = 1; read_cnt = 2;
    cycle();
    checks++; if (occ(1) != 0) begin errors++; $display("FAIL uflow occ1: got %0d want 0", occ(1)); end
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uflow flag: got %b want 1", err_underflow); end
    checks++; if (read_vld !== 2'b00) begin errors++; $display("FAIL uflow vld: got %b want 00", read_vld); end
    idle(); read_thread = 1; write_wen = 1; write_thread = 1; write_cnt = 2;
    write_data = 32'h0000_E2E1;
    cycle();
    checks++; if (read_vld !== 2'b11) begin errors++; $display("FAIL uflow refill vld: got %b want 11", read_vld); end
    checks++; if (lane(0) !== 8'hE1) begin errors++; $display("FAIL uflow rdptr lane0: got %h want e1", lane(0)); end
    checks++; if (lane(1) !== 8'hE2) begin errors++; $display("FAIL uflow rdptr lane1: got %h want e2", lane(1)); end
    checks++; if (err_lanes !== 1'b0) begin errors++; $display("FAIL uflow err_lanes: got %b want 0", err_lanes); end
  endtask

  task automatic test_wrap();
    idle();
    write_wen = 1; write_thread = 0; write_cnt = 4; write_data = $urandom;
    read_thread = 0; read_cnt = 2;
    cycle();
    checks++; if (occ(0) != 11) begin errors++; $display("FAIL wrap rejected: got %0d want 11", occ(0)); end
    idle(); read_thread = 0; read_cnt = 1;
    cycle();
    checks++; if (occ(0) != 10) begin errors++; $display("FAIL wrap occ10: got %0d want 10", occ(0)); end
    write_wen = 1; write_thread = 0; write_cnt = 4; write_data = $urandom; read_cnt = 2;
    cycle();
    checks++; if (occ(0) != 12) begin errors++; $display("FAIL wrap occ12: got %0d want 12", occ(0)); end
    idle(); read_thread = 0; read_cnt = 2;
    for (int n = 0; n < 6; n++) begin
      cycle();
      checks++; if (occ(0) != mq[0].size()) begin
        errors++; $display("FAIL wrap drain occ: got %0d want %0d", occ(0), mq[0].size());
      end
      checks++; if (read_vld !== exp_vld()) begin
        errors++; $display("FAIL wrap drain vld: got %b want %b", read_vld, exp_vld());
      end
      for (int i = 0; i < RD; i++) begin
        if (i < win_n) begin
          checks++; if (lane(i) !== mq[0][i]) begin
            errors++; $display("FAIL wrap drain lane%0d: got %h want %h", i, lane(i), mq[0][i]);
          end
        end
      end
    end
    checks++; if (occ(0) != 0) begin errors++; $display("FAIL wrap empty: got %0d want 0", occ(0)); end
  endtask

  task automatic test_flush();
    idle();
    except = 1; except_thread = 1; read_thread = 1;
    write_wen = 1; write_thread = 0; write_cnt = 2; write_data = $urandom;
    cycle();
    checks++; if (occ(1) != 0) begin errors++; $display("FAIL flush occ1: got %0d want 0", occ(1)); end
    checks++; if (occ(0) != 2) begin errors++; $display("FAIL flush occ0: got %0d want 2", occ(0)); end
    checks++; if (read_vld !== 2'b00) begin errors++; $display("FAIL flush vld: got %b want 00", read_vld); end
    idle();
    except = 1; except_thread = 1; read_thread = 1;
    write_wen = 1; write_thread = 1; write_cnt = 3; write_data = $urandom;
    cycle();
    checks++; if (occ(1) != 0) begin errors++; $display("FAIL flush same-thread wr: got %0d want 0", occ(1)); end
  endtask

  task automatic test_stall();
    logic [7:0] h0, h1, h2, h3;
    idle();
    write_wen = 1; write_thread = 0; write_cnt = 4; write_data = $urandom; read_thread = 0;
    cycle();
    h0 = mq[0][0]; h1 = mq[0][1]; h2 = mq[0][2]; h3 = mq[0][3];
    idle(); read_thread = 0; read_cnt = 2; stall = 1;
    for (int n = 0; n < 3; n++) begin
      cycle();
      checks++; if (occ(0) != 6) begin errors++; $display("FAIL stall occ: got %0d want 6", occ(0)); end
      checks++; if (read_vld !== 2'b11) begin errors++; $display("FAIL stall vld: got %b want 11", read_vld); end
      checks++; if (read_data !== {h1, h0}) begin
        errors++; $display("FAIL stall data: got %h want %h", read_data, {h1, h0});
      end
    end
    stall = 0;
    cycle();
    checks++; if (occ(0) != 4) begin errors++; $display("FAIL unstall occ: got %0d want 4", occ(0)); end
    checks++; if (read_data !== {h3, h2}) begin
      errors++; $display("FAIL unstall data: got %h want %h", read_data, {h3, h2});
    end
  endtask

  task automatic test_lanes();
    idle();
    write_wen = 1; write_thread = 1; write_first = 3; write_cnt = 3;
    write_data = {8'h77, 8'h66, 8'h55, 8'h44}; read_thread = 1;
    cycle();
    checks++; if (occ(1) != 1) begin errors++; $display("FAIL lanes occ1: got %0d want 1", occ(1)); end
    checks++; if (err_lanes !== 1'b1) begin errors++; $display("FAIL lanes flag: got %b want 1", err_lanes); end
    checks++; if (read_vld !== 2'b01) begin errors++; $display("FAIL lanes vld: got %b want 01", read_vld); end
    checks++; if (lane(0) !== 8'h77) begin errors++; $display("FAIL lanes data: got %h want 77", lane(0)); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      stall         = ($urandom_range(0, 3) == 0);
      fStall        = ($urandom_range(0, 7) == 0);
      write_wen     = ($urandom_range(0, 3) != 0);
      write_thread  = 1'($urandom_range(0, 1));
      write_first   = 2'($urandom_range(0, 3));
      write_cnt     = 3'($urandom_range(0, 5));
      write_data    = $urandom;
      read_thread   = 1'($urandom_range(0, 1));
      read_cnt      = 2'($urandom_range(0, 2));
      except        = !stall && ($urandom_range(0, 15) == 0);
      except_thread = 1'($urandom_range(0, 1));
      cycle();
      for (int t = 0; t < TH; t++) begin
        checks++; if (occ(t) != mq[t].size()) begin
          errors++; $display("FAIL rand occ%0d cyc %0d: got %0d want %0d", t, n, occ(t), mq[t].size());
        end
      end
      checks++; if (doFStall !== exp_fstall()) begin
        errors++; $display("FAIL rand doFStall cyc %0d: got %b want %b", n, doFStall, exp_fstall());
      end
      checks++; if (read_vld !== exp_vld()) begin
        errors++; $display("FAIL rand vld cyc %0d: got %b want %b", n, read_vld, exp_vld());
      end
      for (int i = 0; i < RD; i++) begin
        if (i < win_n) begin
          checks++; if (lane(i) !== mq[win_thr][i]) begin
            errors++; $display("FAIL rand lane%0d cyc %0d: got %h want %h", i, n, lane(i), mq[win_thr][i]);
          end
        end
      end
      checks++; if ({err_underflow, err_lanes} !== {m_err_u, m_err_l}) begin
        errors++; $display("FAIL rand errs cyc %0d: got %b want %b", n,
                           {err_underflow, err_lanes}, {m_err_u, m_err_l});
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_first();
    test_fstall();
    test_underflow();
    test_wrap();
    test_flush();
    test_stall();
    test_lanes();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instrq_side_fifo.md
Name: instrq_side_fifo

Overview:
- Parametrised per-thread side-data queue running alongside the main instruction queue in the backend.
- Each cycle it accepts a packed group of up to WR_PORTS side-data entries for one thread, and presents the next RD_PORTS head entries of one thread as a peek window.
- It provides per-thread occupancy, per-thread front-end stall, and per-thread flush.
- Compared with the two-thread, fixed-16-deep version it generalises thread count, depth and lane counts, uses binary counts, clamps underflow, and flags errors.

Parameters:
DATA_WIDTH, `instrQExtra_width, bits per entry
THREADS, 2, hardware threads; each owns a private ring
DEPTH, 16, entries per thread; power of two, at least 2*WR_PORTS
WR_PORTS, 4, write lanes per cycle
RD_PORTS, 2, read/peek lanes per cycle
FSTALL_SLACK, 0, extra entries of headroom reserved before doFStall asserts

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
except  in  1  flush request
except_thread  in  TW=max(1,clog2(THREADS))  thread to flush
fStall  in  1  front-end stalled; suppresses writes
doFStall  out  THREADS  per-thread stall request to front end
stall  in  1  backend stalled; suppresses dequeue and read-address update
read_thread  in  TW  thread being read
read_cnt  in  clog2(RD_PORTS+1)  binary count of entries dequeued this cycle
read_data  out  RD_PORTS*DATA_WIDTH  peek window; lane i holds head+i
read_vld  out  RD_PORTS  lane i valid
write_wen  in  1  write request
write_thread  in  TW  thread being written
write_first  in  clog2(WR_PORTS)  index of first valid input lane
write_cnt  in  clog2(WR_PORTS+1)  binary count of valid lanes
write_data  in  WR_PORTS*DATA_WIDTH  input lanes, packed, lane 0 LSB
occupancy  out  THREADS*clog2(DEPTH+1)  registered per-thread count
err_underflow  out  1  sticky; read_cnt exceeded occupancy
err_lanes  out  1  sticky; write_first+write_cnt exceeded WR_PORTS

Behaviour:
- Storage is THREADS*DEPTH entries, addressed {thread, ptr}. Per thread: wr_ptr, rd_ptr, cnt, all reset to 0.
- Async reset clears every counter/pointer, doFStall=0, read_vld=0, both error flags=0. RAM contents are not reset. read_data is don't-care while read_vld=0.
- Write accept: wacc = write_wen & ~fStall & ~doFStall[write_thread] & write_cnt!=0.
  - On wacc, lanes write_first .. write_first+write_cnt-1 go to wr_ptr+0 .. wr_ptr+write_cnt-1 (mod DEPTH).
  - wr_ptr += write_cnt.
  - Lanes at or beyond WR_PORTS are dropped and not counted; err_lanes sets.
- Read accept: racc = ~stall.
  - eff = min(read_cnt, cnt[read_thread]).
  - rd_ptr += eff.
  - If read_cnt > cnt, err_underflow sets.
- Count update per thread: cnt_next = cnt + (wacc&&thread match ? accepted lanes : 0) - (racc&&thread match ? eff : 0). Simultaneous write and read on the same thread is legal.
- doFStall[t] is combinational from the registered count: cnt[t] >= DEPTH-WR_PORTS+1-FSTALL_SLACK. With defaults this gives 13. It therefore never asserts before a full write can still be absorbed.
- Peek window:
  - The read address register is loaded only when ~stall, with {read_thread, rd_ptr_next[read_thread]+i}.
  - read_data lane i is RAM[addr_reg_i], read asynchronously. Write-first: an entry written at the same edge is visible.
  - read_vld[i] is registered: loaded when ~stall with (cnt_next[read_thread] > i); held while stall.
  - One-cycle latency from dequeue to the new window.
- Flush:
  - except clears cnt, rd_ptr and wr_ptr of except_thread only. Writes and reads to that thread in the same cycle are discarded.
  - Other threads update normally.
  - If read_thread==except_thread and ~stall, read_vld is loaded as 0.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally; cnt is log2(DEPTH)+1 bits and reaches DEPTH exactly.
- Overflow cannot occur while the front end honours doFStall. A write with cnt+accepted > DEPTH is an assertion failure, not handled.
- Error flags clear only on rst.

Decomposition:
- Shared package instrq_pkg holds: the DATA_WIDTH macro mapping, a TW/count-width helper function (clog2), and the stall threshold function.
- Sub-module iqs_thread_ctrl, one instance per thread (generate):
  - holds wr_ptr, rd_ptr and cnt;
  - computes eff, next pointers and doFStall;
  - handles flush.
- The RAM is inferred in the top level, with WR_PORTS write ports and RD_PORTS read ports.

Test Plan:
- Reset, then thread 0 writes write_first=1, write_cnt=3 (lanes A,B,C), read_cnt=0 -> next cycle occupancy[0]=3, read_vld=11, read_data lanes = A,B.
- Thread 0 holds 12 entries, writes 1 more -> cnt=13, doFStall[0]=1, doFStall[1]=0. A further write with write_wen=1 is ignored and cnt stays 13.
- Thread 1 cnt=1, read_cnt=2 -> cnt becomes 0, err_underflow=1, read_vld=00, rd_ptr advances by 1 only.
- Same cycle: thread 0 writes 4 and reads 2, with cnt=15 before, DEPTH=16 and ptrs near 15 -> cnt=17 rejected since doFStall was 1. Repeat with cnt=10 -> cnt=12, pointers wrap through 0 and data order is preserved.
- except on thread 1 while thread 0 writes 2 -> thread 1 cnt/ptrs = 0, thread 0 cnt += 2.
- stall=1 with read_cnt=2 for 3 cycles -> pointers, read_data and read_vld unchanged. Release -> window advances by 2 after one cycle.
